rv_iopmp_reg_access_fsm: RTL and testbench
==========================================

Name: rv_iopmp_reg_access_fsm

Overview:
- Upstream access sequencer for the IOPMP register-slice array.
- Accepts single-beat register requests on a valid/ready channel and decodes each to one register index.
- Drives a one-cycle write-enable or read-pulse plus merged write data into the per-register slices, samples their software-visible values, and returns a response on a second valid/ready channel.
- One transaction in flight at a time; handles byte-enable merging, lock-based write protection and decode errors.

Parameters:
- NUM_REGS, 16, number of 32-bit registers behind the block; index = addr[AW-1:2]
- AW, 8, request byte-address width; must satisfy 2^(AW-2) >= NUM_REGS
- DW, 32, register data width; fixed at 32, byte enables DW/8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  AW  byte address
- req_write_i  in  1  1=write, 0=read
- req_wdata_i  in  DW  write data
- req_be_i  in  DW/8  byte enables (writes only)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DW  read data (0 for writes and errors)
- rsp_err_o  out  1  decode/protection error
- reg_we_o  out  NUM_REGS  one-hot write-enable pulse to slice i
- reg_re_o  out  NUM_REGS  one-hot read pulse (for read-clear slices)
- reg_wd_o  out  DW  merged write data, shared by all slices
- reg_qs_i  in  NUM_REGS*DW  software-visible value of each slice, reg i at [i*DW +: DW]
- reg_wr_allow_i  in  NUM_REGS  1=register writable (0 when locked)

Behaviour:
- Reset: synchronous on rst_i at the clock edge.
  - State goes to IDLE; all capture registers cleared.
  - req_ready_o = 1 and rsp_valid_o = 0 in the first cycle after reset.
  - reg_we_o, reg_re_o, reg_wd_o, rsp_rdata_o and rsp_err_o are 0.
  - Reset during ACCESS or RESP drops the transaction: no further pulse, no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, latch addr, write, wdata and be, then go to ACCESS.
- ACCESS (exactly one cycle; req_ready_o = 0):
  - idx = addr[AW-1:2].
  - err = (addr[1:0] != 0) | (idx >= NUM_REGS) | (write & !reg_wr_allow_i[idx]).
  - Write, no err, be != 0:
    - reg_we_o[idx] = 1.
    - reg_wd_o byte k = be[k] ? wdata byte k : reg_qs_i[idx] byte k.
  - Write with be == 0: no pulse, no error (silent no-op).
  - Read, no err: reg_re_o[idx] = 1; capture rdata = reg_qs_i[idx] sampled this cycle.
  - Any err: no pulse on reg_we_o or reg_re_o; rdata = 0.
  - Always go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
  - req_ready_o = 0 throughout RESP.
- Timing:
  - Request accepted at edge N; we/re pulse during cycle N+1; rsp_valid_o asserted from cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
  - A new request may be offered in the cycle after the response handshake.
- reg_we_o and reg_re_o are never both non-zero, and at most one bit of each is set.
- reg_wd_o is 0 whenever reg_we_o == 0.
- Indices are computed at full AW width; no wrap-around. Addresses beyond NUM_REGS*4 return err.
- Inputs other than handshake signals are ignored outside their sampling cycles.

Test Plan:
- Reset, then read addr 0x04 with reg_qs_i[1] = 0xDEADBEEF:
  - reg_re_o = 0x0002 for exactly one cycle.
  - rsp_rdata_o = 0xDEADBEEF, rsp_err_o = 0, two cycles after acceptance.
- Write addr 0x08, wdata = 0x11223344, be = 0b0101, reg_qs_i[2] = 0xAABBCCDD, allow = 1:
  - one-cycle reg_we_o = 0x0004, reg_wd_o = 0xAA22CC44.
  - rsp_err_o = 0, rsp_rdata_o = 0.
- Error paths, each must produce no pulse, rsp_err_o = 1 and rsp_rdata_o = 0:
  - write addr 0x0C with reg_wr_allow_i[3] = 0;
  - read addr 0x41 (misaligned);
  - read addr 0x40 with NUM_REGS = 16 (out of range).
- Hold rsp_ready_i = 0 for 5 cycles after a read:
  - rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0.
  - A request offered meanwhile is not accepted until the cycle after the response handshake.
- Write with be = 0:
  - reg_we_o stays 0 and the response has rsp_err_o = 0.
  - Back-to-back valid requests are accepted every 3 cycles when rsp_ready_i = 1.
- Assert rst_i during ACCESS of a write:
  - no reg_we_o pulse after the reset edge and no response.
  - req_ready_o = 1 the cycle after rst_i deasserts.

Source files
------------

// File: rtl/rv_iopmp_reg_access_fsm.sv
// ----------------------------------------------------------------------------
// rv_iopmp_reg_access_fsm
//
// Upstream access sequencer for the IOPMP register-slice array. Takes one
// single-beat register request at a time, decodes it to a register index,
// issues a one-cycle write-enable (with byte-merged data) or read pulse to
// the addressed slice, and returns the result on a response channel.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_addr_i            byte address (index = addr[AW-1:2])
//   req_write_i           1 = write, 0 = read
//   req_wdata_i, req_be_i write data and byte enables
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data (0 for writes and errors)
//   rsp_err_o             decode / misalignment / lock error
//   reg_we_o, reg_re_o    one-hot write / read pulses to the slices
//   reg_wd_o              merged write data shared by all slices
//   reg_qs_i              packed software-visible slice values
//   reg_wr_allow_i        per-register write permission (0 when locked)
// ----------------------------------------------------------------------------
module rv_iopmp_reg_access_fsm #(
  parameter int NUM_REGS = 16,
  parameter int AW       = 8,
  parameter int DW       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AW-1:0]          req_addr_i,
  input  logic                   req_write_i,
  input  logic [DW-1:0]          req_wdata_i,
  input  logic [DW/8-1:0]        req_be_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DW-1:0]          rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [NUM_REGS-1:0]    reg_we_o,
  output logic [NUM_REGS-1:0]    reg_re_o,
  output logic [DW-1:0]          reg_wd_o,
  input  logic [NUM_REGS*DW-1:0] reg_qs_i,
  input  logic [NUM_REGS-1:0]    reg_wr_allow_i
);

  localparam int BW = DW / 8;
  localparam int IW = AW - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Request capture (p0) and response capture (p1) registers
  logic [AW-1:0] addr_p0;
  logic          write_p0;
  logic [DW-1:0] wdata_p0;
  logic [BW-1:0] be_p0;
  logic [DW-1:0] rdata_p1;
  logic          err_p1;

  logic [IW-1:0]       idx;
  logic [NUM_REGS-1:0] sel_oh;
  logic [DW-1:0]       sel_qs;
  logic                sel_allow;
  logic                hit;
  logic                err;

  // Byte-lane merge: enabled lanes take the new data, others keep the
  // slice's current value so a partial write leaves them untouched.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] wd,
                                                input logic [DW-1:0] cur,
                                                input logic [BW-1:0] be);
    logic [DW-1:0] m;
    for (int k = 0; k < BW; k++) begin
      m[8*k +: 8] = be[k] ? wd[8*k +: 8] : cur[8*k +: 8];
    end
    return m;
  endfunction

  // Decode the captured address. The full-width index is compared against
  // every implemented register, so out-of-range indices simply miss (no
  // wrap-around) and never index past reg_qs_i.
  always_comb begin
    idx       = addr_p0[AW-1:2];
    sel_oh    = '0;
    sel_qs    = '0;
    sel_allow = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) begin
        sel_oh[i] = 1'b1;
        sel_qs    = reg_qs_i[i*DW +: DW];
        sel_allow = reg_wr_allow_i[i];
      end
    end
    hit = |sel_oh;
    err = (addr_p0[1:0] != 2'b00) | ~hit | (write_p0 & ~sel_allow);
  end

  // Next-state and slice strobes. Strobes are suppressed while rst_i is
  // high so a transaction caught by reset never reaches a slice.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    reg_we_o    = '0;
    reg_re_o    = '0;
    reg_wd_o    = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = ~rst_i;
        if (req_valid_i) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!err && !rst_i) begin
          if (write_p0) begin
            // An all-zero byte enable is a silent no-op
            if (|be_p0) begin
              reg_we_o = sel_oh;
              reg_wd_o = merge_bytes(wdata_p0, sel_qs, be_p0);
            end
          end else begin
            reg_re_o = sel_oh;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_p1;
  assign rsp_err_o   = err_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_p0  <= '0;
      write_p0 <= 1'b0;
      wdata_p0 <= '0;
      be_p0    <= '0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage p0: request accepted in IDLE
      if (state_q == IDLE && req_valid_i) begin
        addr_p0  <= req_addr_i;
        write_p0 <= req_write_i;
        wdata_p0 <= req_wdata_i;
        be_p0    <= req_be_i;
      end
      // Stage p1: slice value sampled in the access cycle, held through RESP
      if (state_q == ACCESS) begin
        err_p1   <= err;
        rdata_p1 <= (!err && !write_p0) ? sel_qs : '0;
      end
    end
  end

endmodule

// File: tb/tb_rv_iopmp_reg_access_fsm.sv
// ----------------------------------------------------------------------------
// tb_rv_iopmp_reg_access_fsm
//
// Self-checking bench for rv_iopmp_reg_access_fsm: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a transaction-level
// reference model (busy flag, cycles since acceptance, decoded result).
// ----------------------------------------------------------------------------
module tb_rv_iopmp_reg_access_fsm;

  localparam int NR = 16;
  localparam int AW = 8;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [NR-1:0]     reg_we, reg_re, allow;
  logic [DW-1:0]     reg_wd;
  logic [NR*DW-1:0]  reg_qs;
  logic [31:0]       qs [NR];

  always_comb begin
    reg_qs = '0;
    for (int i = 0; i < NR; i++) reg_qs[i*DW +: DW] = qs[i];
  end

  rv_iopmp_reg_access_fsm #(.NUM_REGS(NR), .AW(AW), .DW(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_write_i    (req_write),
    .req_wdata_i    (req_wdata),
    .req_be_i       (req_be),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .reg_we_o       (reg_we),
    .reg_re_o       (reg_re),
    .reg_wd_o       (reg_wd),
    .reg_qs_i       (reg_qs),
    .reg_wr_allow_i (allow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: transaction-level view
  bit          m_busy, m_clean, m_err;
  int          m_age;
  logic [7:0]  m_addr;
  bit          m_wr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_be;

  // Snapshot of DUT outputs from the most recent step
  bit          s_ready, s_valid, s_acc, s_hs, s_err;
  logic [15:0] s_we, s_re;
  logic [31:0] s_wd, s_rdata;

  // One clock cycle: sample and check mid-cycle, then advance the model
  // across the edge using the inputs that were stable before it.
  task automatic step();
    bit          exp_valid, derr, cap_err;
    int          idx;
    logic [15:0] e_we, e_re;
    logic [31:0] e_wd, cap_rdata;
    bit          p_rst, p_rv, p_rr, p_wr;
    logic [7:0]  p_addr;
    logic [31:0] p_wd;
    logic [3:0]  p_be;
    #3;
    cyc++;
    s_ready = req_ready;  s_valid = rsp_valid;  s_err = rsp_err;
    s_we = reg_we;  s_re = reg_re;  s_wd = reg_wd;  s_rdata = rsp_rdata;
    s_acc = req_valid & req_ready;
    s_hs  = rsp_valid & rsp_ready;
    e_we = '0;  e_re = '0;  e_wd = '0;  cap_rdata = '0;  cap_err = 1'b0;
    if (m_busy && m_age == 1) begin
      idx  = int'(m_addr) / 4;
      derr = (m_addr % 4 != 0) || (idx >= NR);
      if (!derr && m_wr && !allow[idx]) derr = 1'b1;
      if (!derr && m_wr && m_be != 4'h0) begin
        e_we = 16'(1) << idx;
        for (int k = 0; k < 4; k++)
          e_wd[8*k +: 8] = m_be[k] ? m_wdata[8*k +: 8] : qs[idx][8*k +: 8];
      end
      if (!derr && !m_wr) begin
        e_re      = 16'(1) << idx;
        cap_rdata = qs[idx];
      end
      cap_err = derr;
    end
    exp_valid = m_busy && m_age >= 2;
    if (rst) begin
      check_val("we_in_rst", 64'(s_we), 64'(0));
      check_val("re_in_rst", 64'(s_re), 64'(0));
    end else begin
      check_val("req_ready", 64'(s_ready), 64'(!m_busy));
      check_val("rsp_valid", 64'(s_valid), 64'(exp_valid));
      check_val("reg_we", 64'(s_we), 64'(e_we));
      check_val("reg_re", 64'(s_re), 64'(e_re));
      check_val("reg_wd", 64'(s_wd), 64'(e_wd));
      if (exp_valid || m_clean) begin
        check_val("rsp_rdata", 64'(s_rdata), 64'(m_rdata));
        check_val("rsp_err", 64'(s_err), 64'(m_err));
      end
    end
    p_rst = rst;  p_rv = req_valid;  p_rr = rsp_ready;  p_wr = req_write;
    p_addr = req_addr;  p_wd = req_wdata;  p_be = req_be;
    @(posedge clk);
    if (p_rst) begin
      m_busy = 1'b0;  m_age = 0;  m_rdata = '0;  m_err = 1'b0;  m_clean = 1'b1;
    end else if (m_busy) begin
      if (m_age == 1) begin
        m_age = 2;  m_rdata = cap_rdata;  m_err = cap_err;  m_clean = 1'b0;
      end else if (p_rr) begin
        m_busy = 1'b0;
      end
    end else if (p_rv) begin
      m_busy = 1'b1;  m_age = 1;
      m_addr = p_addr;  m_wr = p_wr;  m_wdata = p_wd;  m_be = p_be;
    end
    #1;
  endtask

  // Per-transaction observations
  int          o_wait, o_pulses, o_acc_cyc;
  logic [15:0] o_we, o_re;
  logic [31:0] o_wd, o_rdata;
  bit          o_err;

  // Offer one request, hold the response for 'hold' cycles, then consume it.
  // With 'offer' set, req_valid stays high afterwards (next request queued).
  task automatic run_txn(input logic [7:0] a, input bit w, input logic [31:0] d,
                         input logic [3:0] b, input int hold, input bit offer);
    bit done;
    req_addr = a;  req_write = w;  req_wdata = d;  req_be = b;
    req_valid = 1'b1;  rsp_ready = (hold == 0);
    o_wait = 0;  o_pulses = 0;  o_we = '0;  o_re = '0;  o_wd = '0;
    o_rdata = '0;  o_err = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      step();
      if (s_acc) done = 1'b1;
      else o_wait++;
    end
    if (!done) begin
      check_val("accept_timeout", 64'(0), 64'(1));
      req_valid = 1'b0;
      return;
    end
    o_acc_cyc = cyc;
    req_valid = offer;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      step();
      if (s_we != 0 || s_re != 0) begin
        o_pulses++;  o_we |= s_we;  o_re |= s_re;  o_wd |= s_wd;
      end
      if (offer) check_val("busy_no_accept", 64'(s_acc), 64'(0));
      if (s_valid) done = 1'b1;
    end
    if (!done) begin
      check_val("rsp_timeout", 64'(0), 64'(1));
      req_valid = 1'b0;  rsp_ready = 1'b1;
      return;
    end
    check_val("rsp_latency", 64'(cyc - o_acc_cyc), 64'd2);
    o_rdata = s_rdata;  o_err = s_err;
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        step();
        check_val("hold_valid", 64'(s_valid), 64'(1));
        check_val("hold_ready", 64'(s_ready), 64'(0));
        check_val("hold_rdata", 64'(s_rdata), 64'(o_rdata));
        check_val("hold_err", 64'(s_err), 64'(o_err));
        if (offer) check_val("hold_no_accept", 64'(s_acc), 64'(0));
      end
      rsp_ready = 1'b1;
      step();
      check_val("rsp_handshake", 64'(s_hs), 64'(1));
      if (offer) check_val("hs_no_accept", 64'(s_acc), 64'(0));
    end else begin
      check_val("rsp_handshake", 64'(s_hs), 64'(1));
    end
    req_valid = offer;
  endtask

  int prev_acc;
  bit got;

  initial begin
    rst = 1'b1;  req_valid = 1'b0;  req_addr = '0;  req_write = 1'b0;
    req_wdata = '0;  req_be = '0;  rsp_ready = 1'b1;  allow = '1;
    for (int i = 0; i < NR; i++) qs[i] = '0;
    m_busy = 1'b0;  m_age = 0;  m_clean = 1'b1;  m_rdata = '0;  m_err = 1'b0;
    m_addr = '0;  m_wr = 1'b0;  m_wdata = '0;  m_be = '0;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    step();
    check_val("reset_ready", 64'(s_ready), 64'(1));
    check_val("reset_valid", 64'(s_valid), 64'(0));
    check_val("reset_rdata", 64'(s_rdata), 64'(0));
    check_val("reset_err", 64'(s_err), 64'(0));

    // Plain read
    qs[1] = 32'hDEADBEEF;
    run_txn(8'h04, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    check_val("rd_re", 64'(o_re), 64'h0002);
    check_val("rd_pulses", 64'(o_pulses), 64'd1);
    check_val("rd_rdata", 64'(o_rdata), 64'hDEADBEEF);
    check_val("rd_err", 64'(o_err), 64'(0));

    // Partial write with byte merge
    qs[2] = 32'hAABBCCDD;
    run_txn(8'h08, 1'b1, 32'h11223344, 4'b0101, 0, 1'b0);
    check_val("wr_we", 64'(o_we), 64'h0004);
    check_val("wr_wd", 64'(o_wd), 64'hAA22CC44);
    check_val("wr_pulses", 64'(o_pulses), 64'd1);
    check_val("wr_err", 64'(o_err), 64'(0));
    check_val("wr_rdata", 64'(o_rdata), 64'(0));

    // Error paths: locked write, misaligned read, out-of-range read
    allow[3] = 1'b0;
    run_txn(8'h0C, 1'b1, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    check_val("lock_pulses", 64'(o_pulses), 64'(0));
    check_val("lock_err", 64'(o_err), 64'(1));
    check_val("lock_rdata", 64'(o_rdata), 64'(0));
    allow[3] = 1'b1;
    run_txn(8'h41, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    check_val("misal_pulses", 64'(o_pulses), 64'(0));
    check_val("misal_err", 64'(o_err), 64'(1));
    check_val("misal_rdata", 64'(o_rdata), 64'(0));
    run_txn(8'h40, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    check_val("oor_pulses", 64'(o_pulses), 64'(0));
    check_val("oor_err", 64'(o_err), 64'(1));
    check_val("oor_rdata", 64'(o_rdata), 64'(0));

    // Response back-pressure with a request waiting
    qs[5] = 32'h5A5A0FF0;
    run_txn(8'h14, 1'b0, 32'h0, 4'h0, 5, 1'b1);
    check_val("bp_rdata", 64'(o_rdata), 64'h5A5A0FF0);
    run_txn(8'h14, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    check_val("accept_after_hs", 64'(o_wait), 64'(0));

    // Zero byte-enable write is a silent no-op
    run_txn(8'h08, 1'b1, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    check_val("be0_we", 64'(o_we), 64'(0));
    check_val("be0_err", 64'(o_err), 64'(0));

    // Back-to-back requests, one every 3 cycles
    prev_acc = 0;
    for (int t = 0; t < 4; t++) begin
      qs[t] = 32'h1000 + 32'(t);
      run_txn(8'(t * 4), 1'b0, 32'h0, 4'h0, 0, t < 3);
      check_val("b2b_rdata", 64'(o_rdata), 64'(32'h1000 + 32'(t)));
      if (t > 0) check_val("b2b_interval", 64'(o_acc_cyc - prev_acc), 64'd3);
      prev_acc = o_acc_cyc;
    end

    // Reset landing in the access cycle of a write
    req_addr = 8'h08;  req_write = 1'b1;  req_wdata = 32'h12345678;
    req_be = 4'hF;  req_valid = 1'b1;  rsp_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      step();
      got = s_acc;
    end
    check_val("rst_acc_seen", 64'(got), 64'(1));
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    check_val("rst_access_we", 64'(s_we), 64'(0));
    rst = 1'b0;
    step();
    check_val("ready_after_rst", 64'(s_ready), 64'(1));
    check_val("no_rsp_after_rst", 64'(s_valid), 64'(0));
    check_val("no_we_after_rst", 64'(s_we), 64'(0));
    for (int n = 0; n < 3; n++) begin
      step();
      check_val("no_rsp_later", 64'(s_valid), 64'(0));
    end

    // Randomized traffic; slice values and permissions change every cycle
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(99) == 0);
      req_valid = ($urandom_range(99) < 60);
      if ($urandom_range(9) < 7) req_addr = 8'($urandom_range(15) * 4);
      else                       req_addr = 8'($urandom);
      req_write = 1'($urandom_range(1));
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(15));
      rsp_ready = ($urandom_range(99) < 70);
      allow     = 16'($urandom) | 16'($urandom);
      for (int i = 0; i < NR; i++) qs[i] = $urandom;
      step();
    end
    rst = 1'b0;
    req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
